countdown_timer_mmss: RTL and testbench

Parametrised MM:SS countdown timer for the seven-segment timer designs. It takes debounced one-cycle key pulses and counts down from up to MAX_MIN:59, with per-field editing and a timed alarm phase. Optional auto-reload restarts the last started value. Its outputs drive the display/BCD stage and the buzzer/LED driver directly.

---
 rtl/countdown_pkg.sv | 22 ++
 rtl/countdown_tick_gen.sv | 30 +++
 rtl/countdown_timer_mmss.sv | 152 +++++++++++++++
 tb/tb_countdown_timer_mmss.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared encodings and field helpers for the MM:SS countdown timer
package countdown_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic FIELD_SEC = 1'b0;
    localparam logic FIELD_MIN = 1'b1;

    localparam logic [5:0] SEC_LAST = 6'd59;

    // Seconds field edits wrap without carrying into minutes.
    function automatic logic [5:0] sec_edit(input logic [5:0] s, input logic up);
        if (up) return (s == SEC_LAST) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? SEC_LAST : s - 6'd1;
    endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// rtl/countdown_tick_gen.sv - one-second prescaler producing a single-cycle tick
module countdown_tick_gen #(
    parameter int CLK_FREQ_HZ = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_FREQ_HZ - 1);

    logic [W-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    // The count only advances while enabled, so a pause resumes mid-second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_mmss.sv
// rtl/countdown_timer_mmss.sv - MM:SS countdown timer with field editing, alarm phase and auto-reload
module countdown_timer_mmss
    import countdown_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int MAX_MIN     = 99,
    parameter int DEFAULT_MIN = 0,
    parameter int DEFAULT_SEC = 0,
    parameter int ALARM_SEC   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pause_p,
    input  logic       reset_p,
    input  logic       add_p,
    input  logic       sub_p,
    input  logic       field_p,
    input  logic       repeat_en,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       edit_min,
    output logic [1:0] state,
    output logic       running,
    output logic       done_p,
    output logic       alarm
);

    localparam logic [6:0] MAX_MIN_V = 7'(MAX_MIN);
    localparam logic [6:0] DEF_MIN_V = 7'(DEFAULT_MIN);
    localparam logic [5:0] DEF_SEC_V = 6'(DEFAULT_SEC);
    localparam logic [3:0] ALARM_V   = 4'(ALARM_SEC);

    state_t     st, st_next;
    logic [6:0] min_next, load_min, load_min_next;
    logic [5:0] sec_next, load_sec, load_sec_next;
    logic       edit_next;
    logic [3:0] acnt, acnt_next;
    logic       tick, tick_clear, tick_enable, is_zero;

    assign is_zero     = (minutes == 7'd0) && (seconds == 6'd0);
    assign tick_enable = (st == S_RUN) || (st == S_DONE);
    assign state       = st;

    countdown_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (tick_clear),
        .enable (tick_enable),
        .tick   (tick)
    );

    always_comb begin
        st_next       = st;
        min_next      = minutes;
        sec_next      = seconds;
        load_min_next = load_min;
        load_sec_next = load_sec;
        edit_next     = edit_min;
        acnt_next     = '0;
        tick_clear    = (st == S_IDLE);

        if (reset_p) begin
            st_next    = S_IDLE;
            min_next   = load_min;
            sec_next   = load_sec;
            tick_clear = 1'b1;
        end else begin
            case (st)
                S_IDLE, S_PAUSE: begin
                    if (start_pause_p) begin
                        if (st == S_PAUSE) begin
                            st_next = is_zero ? S_IDLE : S_RUN;
                        end else if (!is_zero) begin
                            st_next       = S_RUN;
                            load_min_next = minutes;
                            load_sec_next = seconds;
                        end
                    end else if (field_p) begin
                        edit_next = ~edit_min;
                    end else if (add_p != sub_p) begin
                        if (edit_min == FIELD_MIN) begin
                            if (add_p) min_next = (minutes == MAX_MIN_V) ? minutes : minutes + 7'd1;
                            else       min_next = (minutes == 7'd0) ? minutes : minutes - 7'd1;
                        end else begin
                            sec_next = sec_edit(seconds, add_p);
                        end
                    end
                end
                S_RUN: begin
                    if (start_pause_p) begin
                        st_next = S_PAUSE;
                    end else if (is_zero) begin
                        st_next = S_DONE;
                    end else if (tick) begin
                        if (seconds == 6'd0) begin
                            sec_next = SEC_LAST;
                            min_next = minutes - 7'd1;
                        end else begin
                            sec_next = seconds - 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (start_pause_p) begin
                        st_next = S_IDLE;
                    end else if (acnt == ALARM_V) begin
                        if (repeat_en) begin
                            st_next    = S_RUN;
                            min_next   = load_min;
                            sec_next   = load_sec;
                            tick_clear = 1'b1;
                        end else begin
                            st_next  = S_IDLE;
                            min_next = 7'd0;
                            sec_next = 6'd0;
                        end
                    end else begin
                        acnt_next = acnt + {3'd0, tick};
                    end
                end
                default: st_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IDLE;
            minutes  <= DEF_MIN_V;
            seconds  <= DEF_SEC_V;
            load_min <= DEF_MIN_V;
            load_sec <= DEF_SEC_V;
            edit_min <= FIELD_SEC;
            acnt     <= '0;
            running  <= 1'b0;
            done_p   <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            st       <= st_next;
            minutes  <= min_next;
            seconds  <= sec_next;
            load_min <= load_min_next;
            load_sec <= load_sec_next;
            edit_min <= edit_next;
            acnt     <= acnt_next;
            running  <= (st == S_RUN);
            done_p   <= (st_next == S_DONE) && (st != S_DONE);
            alarm    <= (st_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb/tb_countdown_timer_mmss.sv - self-checking bench for countdown_timer_mmss
module tb_countdown_timer_mmss;

    localparam int F    = 10;
    localparam int AS   = 2;
    localparam int MAXM = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_pause_p, reset_p, add_p, sub_p, field_p, repeat_en;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       edit_min;
    logic [1:0] state;
    logic       running, done_p, alarm;

    int checks = 0;
    int errors = 0;

    countdown_timer_mmss #(
        .CLK_FREQ_HZ (F),
        .MAX_MIN     (MAXM),
        .DEFAULT_MIN (0),
        .DEFAULT_SEC (0),
        .ALARM_SEC   (AS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_pause_p (start_pause_p),
        .reset_p       (reset_p),
        .add_p         (add_p),
        .sub_p         (sub_p),
        .field_p       (field_p),
        .repeat_en     (repeat_en),
        .minutes       (minutes),
        .seconds       (seconds),
        .edit_min      (edit_min),
        .state         (state),
        .running       (running),
        .done_p        (done_p),
        .alarm         (alarm)
    );

    always #5 clk = ~clk;

    // Reference model: value kept as total seconds, alarm as remaining cycles.
    int m_state, m_total, m_load, m_phase, m_left;
    bit m_edit, m_running, m_done_p, m_alarm;

    task automatic m_reset();
        m_state = 0; m_total = 0; m_load = 0; m_phase = 0; m_left = 0;
        m_edit = 0; m_running = 0; m_done_p = 0; m_alarm = 0;
    endtask

    function automatic int edit_val(int total, bit ed, bit up);
        int m;
        int s;
        m = total / 60;
        s = total % 60;
        if (ed) m = up ? ((m < MAXM) ? m + 1 : m) : ((m > 0) ? m - 1 : 0);
        else    s = up ? (s + 1) % 60 : (s + 59) % 60;
        return m * 60 + s;
    endfunction

    task automatic model_step(input bit sp, input bit rp, input bit fp, input bit ap, input bit bp, input bit rep);
        int ps;
        bit wrap;
        ps   = m_state;
        wrap = (m_phase == F - 1);
        m_running = (m_state == 1);
        if (m_state == 1 || m_state == 3) m_phase = (m_phase + 1) % F;
        if (rp) begin
            m_state = 0;
            m_total = m_load;
        end else begin
            case (ps)
                0, 2: begin
                    if (sp) begin
                        if (ps == 2) m_state = (m_total == 0) ? 0 : 1;
                        else if (m_total != 0) begin m_load = m_total; m_state = 1; end
                    end else if (fp) m_edit = !m_edit;
                    else if (ap != bp) m_total = edit_val(m_total, m_edit, ap);
                end
                1: begin
                    if (sp) m_state = 2;
                    else if (m_total == 0) begin m_state = 3; m_left = AS * F; end
                    else if (wrap) m_total = m_total - 1;
                end
                default: begin
                    if (sp) m_state = 0;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            if (rep) begin m_total = m_load; m_state = 1; m_phase = 0; end
                            else begin m_total = 0; m_state = 0; end
                        end
                    end
                end
            endcase
        end
        if (m_state == 0) m_phase = 0;
        m_done_p = (m_state == 3) && (ps != 3);
        m_alarm  = (m_state == 3);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("minutes", int'(minutes), m_total / 60);
        check("seconds", int'(seconds), m_total % 60);
        check("edit_min", int'(edit_min), int'(m_edit));
        check("state", int'(state), m_state);
        check("running", int'(running), int'(m_running));
        check("done_p", int'(done_p), int'(m_done_p));
        check("alarm", int'(alarm), int'(m_alarm));
    endtask

    task automatic step(input bit sp, input bit rp, input bit fp, input bit ap, input bit bp);
        start_pause_p = sp; reset_p = rp; field_p = fp; add_p = ap; sub_p = bp;
        @(posedge clk);
        model_step(sp, rp, fp, ap, bp, repeat_en);
        #1;
        start_pause_p = 0; reset_p = 0; field_p = 0; add_p = 0; sub_p = 0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic expect_val(input string name, input int mm, input int ss, input int st);
        check({name, "_min"}, int'(minutes), mm);
        check({name, "_sec"}, int'(seconds), ss);
        check({name, "_state"}, int'(state), st);
    endtask

    task automatic check_reset_outputs(input string name);
        expect_val(name, 0, 0, 0);
        check({name, "_edit"}, int'(edit_min), 0);
        check({name, "_running"}, int'(running), 0);
        check({name, "_done_p"}, int'(done_p), 0);
        check({name, "_alarm"}, int'(alarm), 0);
    endtask

    task automatic do_rst();
        #2 rst = 1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 0;
        m_reset();
        compare_all();
    endtask

    task automatic run_alarm_case(input bit rep);
        int n;
        int dp;
        do_rst();
        repeat_en = rep;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        idle(14);
        expect_val("pre_pause", 0, 1, 1);
        step(1, 0, 0, 0, 0);
        idle(40);
        expect_val("paused", 0, 1, 2);
        step(1, 0, 0, 0, 0);
        idle(4);
        expect_val("resume4", 0, 1, 1);
        idle(1);
        expect_val("resume5", 0, 0, 1);
        idle(1);
        expect_val("done_entry", 0, 0, 3);
        check("done_p_entry", int'(done_p), 1);
        check("alarm_entry", int'(alarm), 1);
        n = 1;
        dp = 0;
        for (int i = 0; i < 40 && alarm; i++) begin
            idle(1);
            if (alarm) n++;
            if (done_p) dp++;
        end
        check("alarm_len", n, AS * F);
        check("done_p_extra", dp, 0);
        if (rep) begin
            expect_val("reload", 0, 2, 1);
            idle(9);
            expect_val("reload9", 0, 2, 1);
            idle(1);
            expect_val("reload10", 0, 1, 1);
        end else begin
            expect_val("after_alarm", 0, 0, 0);
        end
        repeat_en = 0;
    endtask

    typedef struct {
        bit sp, rp, fp, ap, bp;
        int exp_min, exp_sec;
        bit exp_edit;
        int exp_state;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; repeat_en = 0;
        start_pause_p = 0; reset_p = 0; add_p = 0; sub_p = 0; field_p = 0;
        m_reset();
        #3 check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 0;

        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 59, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 0,  0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 59, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 0, 59, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 0, 59, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 0, 1, 59, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 59, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 59, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 59, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 59, 0, 1};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 59, 0, 1};
        tbl[12] = '{0, 0, 1, 0, 0, 0, 59, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 59, 0, 2};
        tbl[14] = '{0, 0, 0, 1, 0, 0,  0, 0, 2};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 59, 0, 0};

        do_rst();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].sp, tbl[i].rp, tbl[i].fp, tbl[i].ap, tbl[i].bp);
            expect_val($sformatf("vec%0d", i), tbl[i].exp_min, tbl[i].exp_sec, tbl[i].exp_state);
            check($sformatf("vec%0d_edit", i), int'(edit_min), int'(tbl[i].exp_edit));
        end

        // Minutes edit, then first and second decrement timing.
        do_rst();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        expect_val("edit_2min", 2, 0, 0);
        check("edit_min_set", int'(edit_min), 1);
        step(1, 0, 0, 0, 0);
        idle(9);
        expect_val("start9", 2, 0, 1);
        idle(1);
        expect_val("start10", 1, 59, 1);
        idle(10);
        expect_val("start20", 1, 58, 1);

        run_alarm_case(0);
        run_alarm_case(1);

        // Minutes saturation at MAX_MIN.
        do_rst();
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 0);
        expect_val("min_sat", 99, 0, 0);
        step(0, 0, 0, 1, 0);
        expect_val("min_sat_add", 99, 0, 0);

        // reset_p reloads the started value; reset_p beats start_pause_p.
        do_rst();
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        idle(30);
        expect_val("run3s", 0, 27, 1);
        step(0, 1, 0, 0, 0);
        expect_val("reset_p", 0, 30, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_val("rp_over_sp", 0, 30, 0);

        // Asynchronous rst in the middle of a run.
        do_rst();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        expect_val("load_0105", 1, 5, 0);
        step(1, 0, 0, 0, 0);
        idle(13);
        expect_val("run_0104", 1, 4, 1);
        do_rst();

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 499) == 0) repeat_en = ~repeat_en;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
